// File: rtl/multi_edge_catcher.sv
// Multi-channel edge catcher: per-channel async capture lanes feeding a
// lowest-index-first valid/ready event stream in the clk domain.

module mec_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             edge_rst_n,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             cnt_clr,
  input  logic             take,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             pend
);
  localparam int SW = CNT_W + 1;

  logic                   cap_r, cap_f;
  logic                   clr_r, clr_f;
  logic                   clrq_r, clrq_f;
  logic [SYNC_STAGES-1:0] sync_r, sync_f;
  logic                   s_r, s_f;
  logic                   ev, lose;
  logic [SW-1:0]          cnt_base, cnt_sum;

  assign clr_r = !edge_rst_n || clrq_r || !mode[0];
  assign clr_f = !edge_rst_n || clrq_f || !mode[1];

  // Clocked by the raw input so pulses narrower than a clk period are kept.
  always_ff @(posedge din or posedge clr_r)
    if (clr_r) cap_r <= 1'b0;
    else       cap_r <= 1'b1;

  always_ff @(negedge din or posedge clr_f)
    if (clr_f) cap_f <= 1'b0;
    else       cap_f <= 1'b1;

  assign s_r  = sync_r[SYNC_STAGES-1];
  assign s_f  = sync_f[SYNC_STAGES-1];
  assign ev   = rise_pulse | fall_pulse;
  assign lose = ev & pend & ~take;

  always_comb begin
    cnt_base = cnt_clr ? '0 : {1'b0, cnt};
    cnt_sum  = cnt_base + SW'(rise_pulse) + SW'(fall_pulse);
  end

  // clr_q doubles as the delayed sync output for edge detection.
  always_ff @(posedge clk or negedge edge_rst_n)
    if (!edge_rst_n) begin
      sync_r     <= '0;
      sync_f     <= '0;
      clrq_r     <= 1'b0;
      clrq_f     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cnt        <= '0;
      ovf        <= 1'b0;
      pend       <= 1'b0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], cap_r};
      sync_f     <= {sync_f[SYNC_STAGES-2:0], cap_f};
      clrq_r     <= s_r;
      clrq_f     <= s_f;
      rise_pulse <= s_r & ~clrq_r;
      fall_pulse <= s_f & ~clrq_f;
      cnt        <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      ovf        <= (ovf & ~cnt_clr) | lose;
      pend       <= ev | (pend & ~take);
    end
endmodule

module multi_edge_catcher #(
  parameter  int CH          = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 8,
  localparam int CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                edge_rst_n,
  input  logic [CH-1:0]       data_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH-1:0]       rise_pulse,
  output logic [CH-1:0]       fall_pulse,
  output logic [CH*CNT_W-1:0] cnt,
  output logic [CH-1:0]       ovf,
  output logic                evt_valid,
  output logic [CH_W-1:0]     evt_ch,
  input  logic                evt_ready
);
  logic [CH-1:0]   pend, pick, take;
  logic [CH_W-1:0] pick_idx;
  logic            load;

  assign load = !evt_valid || evt_ready;
  assign pick = pend & (~pend + CH'(1));
  assign take = load ? pick : '0;

  always_comb begin
    pick_idx = '0;
    for (int i = CH-1; i >= 0; i--)
      if (pend[i]) pick_idx = CH_W'(i);
  end

  always_ff @(posedge clk or negedge edge_rst_n)
    if (!edge_rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
    end else if (load) begin
      evt_valid <= |pend;
      if (|pend) evt_ch <= pick_idx;
    end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    mec_lane #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) u_lane (
      .clk        (clk),
      .edge_rst_n (edge_rst_n),
      .din        (data_in[g]),
      .mode       (mode[2*g +: 2]),
      .cnt_clr    (cnt_clr[g]),
      .take       (take[g]),
      .rise_pulse (rise_pulse[g]),
      .fall_pulse (fall_pulse[g]),
      .cnt        (cnt[g*CNT_W +: CNT_W]),
      .ovf        (ovf[g]),
      .pend       (pend[g])
    );
  end
endmodule

// File: tb/tb_multi_edge_catcher.sv
// Scoreboard bench: stimulus predicts pulses/events/counts, a forked monitor
// pops and compares whenever the DUT shows a pulse or a handshake.

module tb_multi_edge_catcher;
  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int CW  = 2;
  localparam int CHW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             edge_rst_n = 1'b1;
  logic [CH-1:0]    data_in = '0;
  logic [2*CH-1:0]  mode = '0;
  logic [CH-1:0]    cnt_clr = '0;
  logic [CH-1:0]    rise_pulse, fall_pulse, ovf;
  logic [CH*CW-1:0] cnt;
  logic             evt_valid;
  logic [CHW-1:0]   evt_ch;
  logic             evt_ready = 1'b0;

  multi_edge_catcher #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .edge_rst_n(edge_rst_n), .data_in(data_in), .mode(mode),
    .cnt_clr(cnt_clr), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .cnt(cnt), .ovf(ovf), .evt_valid(evt_valid), .evt_ch(evt_ch),
    .evt_ready(evt_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; bit fall; int cyc; } pexp_t;
  pexp_t         exp_pulse[$];
  int            exp_evt[$];
  int            mcnt[CH];
  logic [CH-1:0] movf = '0;
  int            checks = 0, fails = 0;
  bit            prev_stall = 0;
  logic [CHW-1:0] prev_ch = '0;

  // Ready driver: forced level, or random with stalls capped at 3 cycles.
  bit   rand_ready_en = 0;
  logic ready_force = 1'b0;
  int   stall_run = 0;
  always @(posedge clk) begin
    #1;
    if (rand_ready_en) begin
      if (stall_run >= 3 || $urandom_range(0, 99) < 70) begin
        evt_ready = 1'b1; stall_run = 0;
      end else begin
        evt_ready = 1'b0; stall_run++;
      end
    end else evt_ready = ready_force;
  end

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic match_pulse(input int ch, input bit fall);
    int k = -1;
    for (int j = 0; j < exp_pulse.size(); j++)
      if (exp_pulse[j].ch == ch && exp_pulse[j].fall == fall) begin k = j; break; end
    if (k < 0) begin
      check($sformatf("unexpected_pulse ch%0d fall=%0d", ch, fall), 1, 0);
    end else begin
      int lat = cyc - exp_pulse[k].cyc;
      check($sformatf("pulse_latency_ok ch%0d fall=%0d lat=%0d", ch, fall, lat),
            int'(lat >= SS && lat <= SS + 2), 1);
      exp_pulse.delete(k);
    end
  endtask

  task automatic mon_step();
    if (!edge_rst_n) begin
      prev_stall = 0;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      if (rise_pulse[i]) match_pulse(i, 1'b0);
      if (fall_pulse[i]) match_pulse(i, 1'b1);
    end
    if (prev_stall)
      check("evt_hold", int'({evt_valid, evt_ch}), int'({1'b1, prev_ch}));
    if (evt_valid && evt_ready) begin
      if (exp_evt.size() == 0) check("unexpected_event", int'(evt_ch) + 1, 0);
      else                     check("evt_ch", int'(evt_ch), exp_evt.pop_front());
    end
    prev_stall = evt_valid && !evt_ready;
    prev_ch    = evt_ch;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rise_pulse"}, int'(rise_pulse), 0);
    check({tag, " fall_pulse"}, int'(fall_pulse), 0);
    check({tag, " cnt"},        int'(cnt), 0);
    check({tag, " ovf"},        int'(ovf), 0);
    check({tag, " evt_valid"},  int'(evt_valid), 0);
    check({tag, " evt_ch"},     int'(evt_ch), 0);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  // em: 0 no expectations, 1 pulses+counts, 2 pulses+counts+events.
  task automatic hit(input logic [CH-1:0] mask, input int w, input int em);
    int o;
    @(posedge clk);
    o = $urandom_range(1, 5);
    #(o);
    for (int i = 0; i < CH; i++)
      if (mask[i] && em > 0) begin
        if (mode[2*i]) begin
          exp_pulse.push_back('{i, 1'b0, cyc});
          mcnt[i] = sat(mcnt[i] + 1);
          if (em == 2) exp_evt.push_back(i);
        end
        if (mode[2*i+1]) begin
          mcnt[i] = sat(mcnt[i] + 1);
          // A short pulse in both-mode lands both pulses in one cycle: one event.
          if (em == 2 && (!mode[2*i] || w >= 10)) exp_evt.push_back(i);
        end
      end
    data_in = data_in | mask;
    #(w);
    for (int i = 0; i < CH; i++)
      if (mask[i] && em > 0 && mode[2*i+1]) exp_pulse.push_back('{i, 1'b1, cyc});
    data_in = data_in & ~mask;
  endtask

  task automatic settle(input string tag);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check({tag, " pulses_left"}, exp_pulse.size(), 0);
    check({tag, " events_left"}, exp_evt.size(), 0);
    check({tag, " evt_valid_idle"}, int'(evt_valid), 0);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("%s cnt[%0d]", tag, i), int'(cnt[i*CW +: CW]), mcnt[i]);
      check($sformatf("%s ovf[%0d]", tag, i), int'(ovf[i]), int'(movf[i]));
    end
    exp_pulse.delete();
    exp_evt.delete();
  endtask

  task automatic clear_all();
    @(posedge clk); #1 cnt_clr = '1;
    @(posedge clk); #1 cnt_clr = '0;
    for (int i = 0; i < CH; i++) mcnt[i] = 0;
    movf = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [CH-1:0] m;
    bit seen;
    for (int i = 0; i < CH; i++) mcnt[i] = 0;
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    #2 edge_rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset");
    #2 edge_rst_n = 1'b1;

    // Single short rising pulse on ch2.
    set_mode(2, 2'b01);
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    hit(4'b0100, 3, 2);
    settle("single_rise");
    clear_all();

    // Both edges on ch0 with a 60-unit pulse.
    mode = '0;
    set_mode(0, 2'b11);
    hit(4'b0001, 60, 2);
    settle("both_edges");
    clear_all();

    // Backpressure: ch1 and ch3 together, then ch3 again while stalled.
    mode = '0;
    set_mode(1, 2'b01);
    set_mode(3, 2'b01);
    ready_force = 1'b0;
    hit(4'b1010, 3, 1);
    exp_evt.push_back(1);
    exp_evt.push_back(3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bp_valid", int'(evt_valid), 1);
    check("bp_hold_ch", int'(evt_ch), 1);
    hit(4'b1000, 3, 1);
    movf[3] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_ovf3", int'(ovf[3]), 1);
    ready_force = 1'b1;
    settle("backpressure");
    clear_all();

    // Saturation with the slot stalled, then a clear aligned with a pulse.
    mode = '0;
    set_mode(0, 2'b01);
    ready_force = 1'b0;
    for (int n = 0; n < 5; n++) begin
      hit(4'b0001, 3, 1);
      repeat (10) @(posedge clk);
    end
    exp_evt.push_back(0);
    exp_evt.push_back(0);
    movf[0] = 1'b1;
    ready_force = 1'b1;
    settle("saturate");
    hit(4'b0001, 3, 2);
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (rise_pulse[0]) begin
        seen = 1;
        cnt_clr[0] = 1'b1;
        @(posedge clk); #1 cnt_clr[0] = 1'b0;
      end
    end
    check("clr_align_seen", int'(seen), 1);
    mcnt[0] = 1;
    movf[0] = 1'b0;
    settle("clr_with_pulse");

    // Mode off produces nothing; two rising edges one clk apart give one pulse.
    mode = '0;
    repeat (2) @(posedge clk);
    hit(4'b1111, 3, 1);
    repeat (10) @(posedge clk);
    hit(4'b1111, 40, 1);
    settle("mode_off");
    set_mode(1, 2'b01);
    repeat (2) @(posedge clk);
    hit(4'b0010, 2, 2);
    hit(4'b0010, 2, 0);
    settle("too_close");

    // Reset between capture and pulse, then a fresh edge.
    mode = '0;
    set_mode(2, 2'b01);
    repeat (2) @(posedge clk);
    hit(4'b0100, 3, 0);
    @(posedge clk);
    #2 edge_rst_n = 1'b0;
    for (int i = 0; i < CH; i++) mcnt[i] = 0;
    movf = '0;
    @(negedge clk);
    check_zero("mid_reset");
    repeat (3) @(posedge clk);
    #2 edge_rst_n = 1'b1;
    hit(4'b0100, 3, 2);
    settle("after_reset");

    // Randomized phases: random modes, widths, channel and ready stalls.
    for (int p = 0; p < 4; p++) begin
      clear_all();
      for (int i = 0; i < CH; i++) set_mode(i, 2'($urandom_range(0, 3)));
      rand_ready_en = 1;
      repeat (2) @(posedge clk);
      for (int s = 0; s < 10; s++) begin
        int w;
        m = '0;
        m[$urandom_range(0, CH-1)] = 1'b1;
        w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4))
                                        : 10 * int'($urandom_range(3, 5));
        hit(m, w, 2);
        repeat (12) @(posedge clk);
      end
      rand_ready_en = 0;
      ready_force = 1'b1;
      settle($sformatf("random%0d", p));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/multi_edge_catcher.md
# multi_edge_catcher

Multi-channel, mode-selectable edge catcher for asynchronous inputs whose pulses may be shorter than a `clk` period. Each channel latches the edge with its own asynchronous-clocked capture flop, synchronises it into the `clk` domain and self-clears. It then emits per-channel rise and fall pulses, saturating event counters, sticky overflow flags and a valid/ready event stream naming the channel. It sits at the boundary between unclocked sensor/strobe inputs and the `clk`-domain control logic.

## Interface
Parameters:
- `CH`, 4, number of input channels (1..32).
- `SYNC_STAGES`, 2, synchroniser depth per capture flop (2..4).
- `CNT_W`, 8, width of each per-channel event counter.
- `CH_W`, `$clog2(CH)` (minimum 1), channel index width. This is a derived localparam.

Ports:
- `clk` in 1: system clock.
- `edge_rst_n` in 1: reset, asynchronous, active-low. Clears all state, including the capture flops.
- `data_in` in CH: asynchronous inputs, with no timing relation to `clk`.
- `mode` in 2*CH: per-channel mode, channel i at bits [2i+1:2i].
  - 00 off
  - 01 rising
  - 10 falling
  - 11 both
- `cnt_clr` in CH: synchronous clear of counter i and `ovf[i]`.
- `rise_pulse` out CH: one-cycle pulse per captured rising edge.
- `fall_pulse` out CH: one-cycle pulse per captured falling edge.
- `cnt` out CH*CNT_W: per-channel saturating event count, channel i at [i*CNT_W +: CNT_W].
- `ovf` out CH: sticky flag, set when an event is lost because that channel's pending bit is already set.
- `evt_valid` out 1: the event stream holds an event.
- `evt_ch` out CH_W: channel number of the held event.
- `evt_ready` in 1: consumer accepts the event.

## Operation
- **Capture flops.** Each channel has two capture flops, `cap_r` and `cap_f`.
  - `cap_r` is set to 1 on posedge `data_in[i]`; `cap_f` on negedge.
  - Each flop is asynchronously cleared by `!edge_rst_n` OR its own `clr_q`.
  - Each flop is also held cleared while its edge type is disabled by `mode`.
- **Synchronisation.** Each capture flop feeds a `SYNC_STAGES`-flop synchroniser with output `s`.
  - `clr_q <= s`.
  - Pulse: `rise_pulse[i] <= s_r & ~s_r_d`, and likewise for falling.
  - Self-clear: the capture flop clears once `s` is seen high. `clr_q` releases one cycle after `s` falls.
- **Lost edges.** An edge arriving while that flop's `clr_q` is high is lost. It is not counted and does not set `ovf`.
- **Mode changes.** A `mode` change takes effect at the next `clk` edge. It does not alter counters, pending bits or the stream.
- **Counters.**
  - Each cycle, `cnt[i]` increments by `rise_pulse[i] + fall_pulse[i]` (0, 1 or 2) and saturates at `2^CNT_W-1`.
  - When `cnt_clr[i]` is high in the same cycle as pulses, the result equals the number of pulses in that cycle.
- **Pending bits.**
  - Any pulse on channel i sets `pend[i]`.
  - If `pend[i]` is already 1 and is not cleared that cycle, the event is dropped and `ovf[i]` is set.
  - Two pulses in one cycle on a clear `pend[i]` set it once, with no overflow.
- **Event stream.**
  - When the output slot is empty, or `evt_valid && evt_ready`, load the lowest-index pending channel into `evt_ch` and clear its `pend` bit in the same cycle.
  - If no bit is pending, `evt_valid` goes 0.
  - `evt_ch` is stable while `evt_valid && !evt_ready`.
  - A new pulse on the channel currently held in the slot sets `pend` normally; it is not an overflow.
- **Reset values.** All outputs are 0 at reset: pulses, `cnt`, `ovf`, `evt_valid`, `evt_ch`. Captures, synchronisers, `pend` and `clr_q` are also 0.

## Timing
- **Edge-to-pulse latency.** `SYNC_STAGES+1` `clk` edges after the first `clk` edge at which the capture flop is seen set, with ±1 cycle of metastability uncertainty.
- **Pulse-to-count.** `cnt` updates on the cycle after the pulse.
- **Pulse-to-`evt_valid`.**
  - Through an empty slot: 2 cycles (`pend` set, then load).
- **Minimum edge spacing.** Guaranteed capture of same-type edges on one channel requires spacing of at least 2*SYNC_STAGES+3 `clk` periods. Opposite-type edges are independent.
- **Minimum pulse width.** An input pulse need only meet the capture flop's async clock minimum pulse width; it need not be wider than a `clk` period.
- **Stream throughput.** One event per cycle under continuous `evt_ready`.
- **Reset deassertion.** `edge_rst_n` deassertion mid-operation discards all in-flight edges. The first capture is possible immediately after release.

## Test plan
- **Single rising edge.** `CH`=4, mode 01 on ch2; a 3 ns high pulse on `data_in[2]` with a 10 ns `clk`.
  - Exactly one `rise_pulse[2]`, 3–4 cycles later.
  - `cnt[2]`=1.
  - `evt_ch`=2, `evt_valid` for one cycle with `evt_ready`=1.
- **Both-edges mode.** Mode 11 on ch0; a 60 ns pulse.
  - One rise pulse and one fall pulse, 6 cycles apart.
  - `cnt[0]`=2.
  - Two events on `evt_ch`=0.
  - `ovf[0]`=0.
- **Backpressure and priority.** `evt_ready`=0; single edges on ch3 and ch1 in the same cycle, then ch3 again.
  - `evt_ch` holds the first loaded channel.
  - After `evt_ready`=1, order is ch1 then ch3.
  - `ovf[3]`=1.
- **Saturation and clear.** `CNT_W`=2; 5 spaced edges.
  - `cnt`=3 stuck.
  - `cnt_clr` pulsed in the same cycle as a pulse gives `cnt`=1 and `ovf` cleared.
- **Mode off and too-close edges.**
  - Mode 00: edges produce nothing.
  - Mode 01: two rising edges 1 `clk` apart yield one pulse, `cnt`=1.
- **Reset mid-operation.** Assert `edge_rst_n` low between capture and pulse.
  - No pulse is produced; all outputs are 0.
  - A fresh edge after release is captured normally.
